// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package booth_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned NUM_GROUPS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Triplet codes {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] BOOTH_Z0  = 3'b000;
  localparam logic [2:0] BOOTH_P1A = 3'b001;
  localparam logic [2:0] BOOTH_P1B = 3'b010;
  localparam logic [2:0] BOOTH_P2  = 3'b011;
  localparam logic [2:0] BOOTH_M2  = 3'b100;
  localparam logic [2:0] BOOTH_M1A = 3'b101;
  localparam logic [2:0] BOOTH_M1B = 3'b110;
  localparam logic [2:0] BOOTH_Z1  = 3'b111;

endpackage

// File: rtl/booth_pp_sel.sv
// Booth triplet decode and unshifted 64-bit partial product selection.
module booth_pp_sel
  import booth_pkg::*;
(
  input  logic [2:0]         triplet,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] pp
);

  logic                 neg, zero, one, two;
  logic [2*WIDTH-1:0]   a_sext;
  logic [2*WIDTH-1:0]   mag;

  always_comb begin
    neg  = 1'b0;
    zero = 1'b0;
    one  = 1'b0;
    two  = 1'b0;
    unique case (triplet)
      BOOTH_Z0, BOOTH_Z1:   zero = 1'b1;
      BOOTH_P1A, BOOTH_P1B: one  = 1'b1;
      BOOTH_P2:             two  = 1'b1;
      BOOTH_M2:             begin two = 1'b1; neg = 1'b1; end
      BOOTH_M1A, BOOTH_M1B: begin one = 1'b1; neg = 1'b1; end
    endcase
  end

  assign a_sext = {{WIDTH{a[WIDTH-1]}}, a};

  always_comb begin
    if (zero)     mag = '0;
    else if (two) mag = a_sext << 1;
    else if (one) mag = a_sext;
    else          mag = '0;
    pp = neg ? (~mag + 64'd1) : mag;
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth group per cycle, 16 cycles per product.
module booth_seq_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);
  import booth_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;

  logic [WIDTH:0]     b_ext;
  logic [5:0]         shamt;
  logic [2:0]         triplet;
  logic [2*WIDTH-1:0] pp;
  logic               last_group;

  // b[-1] is an implicit zero below the LSB
  assign b_ext      = {b_q, 1'b0};
  assign shamt      = {1'b0, cnt_q, 1'b0};
  assign triplet    = b_ext[shamt +: 3];
  assign last_group = (cnt_q == 4'(NUM_GROUPS - 1));

  booth_pp_sel u_pp_sel (
    .triplet (triplet),
    .a       (a_q),
    .pp      (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!abort && in_valid) state_d = StCalc;
      StCalc: begin
        if (abort)           state_d = StIdle;
        else if (last_group) state_d = StDone;
      end
      StDone: if (abort || out_ready) state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    prod      = out_valid ? acc_q : '0;
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (abort) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == StIdle && in_valid) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == StCalc) begin
      acc_d = acc_q + (pp << shamt);
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-004 SHALL have port in_valid, input, 1, operands a/b valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts operands.
REQ-006 SHALL have port a, input, 32, signed multiplicand.
REQ-007 SHALL have port b, input, 32, signed multiplier, Booth-recoded.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current operation.
REQ-009 SHALL have port out_valid, output, 1, prod valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts prod.
REQ-011 SHALL have port prod, output, 64, signed two's-complement product a*b.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 SHALL, on an edge with in_valid&in_ready, latch a and b, clear the 64-bit accumulator and the 4-bit group counter, and go to CALC.
REQ-015 SHALL, each CALC edge for group i=0..15, form the triplet {b[2i+1],b[2i],b[2i-1]} with b[-1]=0, then encode it:
- 000/111: zero
- 001/010: +1x
- 011: +2x
- 100: -2x
- 101/110: -1x
REQ-016 SHALL form each partial product from sign-extended a (1x) or a<<1 (2x), two's-complement negated in 64 bits (~pp+1) when negative, shifted left by 2i, and added modulo 2^64 to the accumulator.
REQ-017 SHALL go to DONE on the edge that adds group 15: 16 cycles from the acceptance edge to out_valid.
REQ-018 SHALL hold prod and out_valid stable in DONE until out_valid&out_ready, then return to IDLE on that edge.
REQ-019 SHALL ignore in_valid outside IDLE; operands are never overwritten mid-operation.
REQ-020 SHALL, on abort=1 in CALC or DONE, return to IDLE next edge, clear prod to 0, and produce no out_valid pulse.
REQ-021 SHALL give abort priority over in_valid and out_ready on the same edge; abort in IDLE takes no action and blocks acceptance on that edge.
REQ-022 SHALL make prod equal the accumulator only in DONE, else hold 0.

Reset
REQ-023 SHALL, while rst_n=0, immediately force state IDLE, accumulator/prod 0, counter 0, out_valid 0, in_ready 1.
REQ-024 SHALL treat reset mid-CALC or mid-DONE as abort: the result is discarded and no out_valid occurs after release.
REQ-025 SHALL accept operands on the first edge after rst_n deasserts.

Structure
REQ-026 SHALL place the state enum, WIDTH=32, NUM_GROUPS=16 and the Booth triplet codes in shared package booth_pkg.
REQ-027 SHALL instantiate one combinational sub-module booth_pp_sel (triplet + a -> neg/zero/one/two -> 64-bit unshifted partial product).
REQ-028 SHALL use a single 64-bit adder, with no multiplier operator inferred.

Verification
REQ-029 SHALL check a=3, b=5, out_ready=1 -> out_valid exactly 16 cycles after acceptance, prod=0x000000000000000F.
REQ-030 SHALL check a=0xFFFFFFF9 (-7), b=6 -> prod=0xFFFFFFFFFFFFFFD6; then a=b=0xFFFFFFFF -> prod=0x0000000000000001.
REQ-031 SHALL check corner cases:
- a=b=0x80000000 -> prod=0x4000000000000000
- a=0x7FFFFFFF, b=0x80000000 -> prod=0xC000000080000000
REQ-032 SHALL check a=2, b=3 with out_ready=0 for 5 cycles in DONE -> prod=6 and out_valid held stable, in_ready=0 throughout, a new in_valid ignored; IDLE after the handshake.
REQ-033 SHALL check abort at CALC cycle 8 -> IDLE next edge, prod=0, no out_valid; the next operation 4*4 returns 0x10.
REQ-034 SHALL check rst_n pulsed low at CALC cycle 5 -> outputs reset asynchronously before the next edge; no stale out_valid after release.
